conv_output_framer: RTL
=======================

Name: conv_output_framer

Overview:
- Stage directly downstream of conv_kernel. Consumes its unframed valid/RGB stream and tracks pixel x/y position within the frame.
- Zeroes border pixels whose convolution window was incomplete, tags start-of-frame and end-of-line, and buffers pixels in a FIFO.
- Presents the result on a valid/ready stream to the display/DMA side.
- conv_kernel has no backpressure, so this block absorbs stalls and reports loss.

Parameters:
- LINE_WIDTH, 640, pixels per line.
- FRAME_HEIGHT, 480, lines per frame.
- PIXEL_DEPTH, 8, bits per colour channel.
- KERNEL_SIZE, 3, convolution window size; sets the border width.
- FIFO_DEPTH, 16, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- valid_i  in  1  input pixel strobe (conv_kernel valid_o).
- input_R / input_G / input_B  in  PIXEL_DEPTH each  convolved channels.
- out_valid  out  1  output entry available.
- out_ready  in  1  consumer accepts the entry.
- output_R / output_G / output_B  out  PIXEL_DEPTH each  framed pixel.
- out_sof  out  1  entry is pixel (0,0) of a frame.
- out_eol  out  1  entry is the last pixel of a line.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted at the input.

Behaviour:
- Reset (rst_n=0 at a clk edge): x=0, y=0, FIFO emptied, out_valid=0, output_R/G/B=0, out_sof=0, out_eol=0, overflow=0, frame_done=0.
- Reset mid-frame or with the FIFO non-empty discards all contents. The first valid_i after reset is pixel (0,0).
- Position counters:
  - Each cycle with valid_i=1, x increments. At x=LINE_WIDTH-1, x wraps to 0 and y increments.
  - At x=LINE_WIDTH-1 and y=FRAME_HEIGHT-1, both wrap to 0 and frame_done pulses in the following cycle.
  - Counters advance whether or not the pixel is stored, so geometry survives drops.
- Border rule: if x < KERNEL_SIZE-1 or y < KERNEL_SIZE-1, the stored RGB is 0. Otherwise the input is stored unchanged.
- Tags: sof = (x==0 && y==0); eol = (x==LINE_WIDTH-1). Both are computed from the pre-increment counter values.
- FIFO entry is {sof, eol, R, G, B}.
  - Push when valid_i=1 and the FIFO is not full.
  - Pop when out_valid=1 and out_ready=1.
- Full with valid_i=1 and no pop: the pixel is dropped and overflow is set. overflow clears only on reset.
- Full with a simultaneous pop: the push is accepted, with no drop.
- Empty with a simultaneous push: no bypass. The entry appears with out_valid=1 in the next cycle.
- Latency: a pixel accepted at edge N is presented at edge N+1 when the FIFO is empty.
- Output holding:
  - out_valid=1 with out_ready=0: outputs and tags hold stable until the pop.
  - out_valid=0: outputs hold their last value (0 after reset).
- Widths: x is $clog2(LINE_WIDTH) bits, y is $clog2(FRAME_HEIGHT) bits. The FIFO occupancy count is $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro FRAMER_GRAY_EN.
- Defined: at push time, each non-border pixel is replaced by gray = (R + 2G + B) >> 2. The sum uses PIXEL_DEPTH+2 bit arithmetic. gray is driven onto all three output channels. Border pixels stay 0.
- Undefined: RGB passes through unchanged.

Decomposition:
- Package conv_pkg holds:
  - typedef pixel_t, PIXEL_DEPTH bits.
  - struct framer_entry_t {sof, eol, pixel_t r, g, b}.
  - constant BORDER = KERNEL_SIZE-1.
- One sub-module, sync_fifo: parameterised width and depth; push/pop/full/empty; registered read data; same-cycle push and pop allowed when full.

Test Plan (LINE_WIDTH=4, FRAME_HEIGHT=3, KERNEL_SIZE=3, FIFO_DEPTH=4 unless stated):
- Border and tags: 12 consecutive pixels, RGB=0x10*(index+1) on all channels, out_ready=1.
  - Only indices 10 and 11 emerge nonzero, with values 0xB0 and 0xC0.
  - out_sof on index 0; out_eol on indices 3, 7 and 11.
  - frame_done pulses once, one cycle after index 11 is accepted.
- Backpressure: out_ready=0, push 4 pixels, then a 5th.
  - The 5th pixel is dropped and overflow=1.
  - After out_ready=1, exactly 4 entries drain in order.
  - The next frame's first pixel still carries out_sof=1.
- Full with simultaneous pop: FIFO full, valid_i=1 and out_ready=1 in the same cycle.
  - No drop, overflow stays 0, occupancy stays 4.
- Reset mid-frame: assert rst_n=0 after 6 pixels with 2 still buffered.
  - Next cycle: out_valid=0 and outputs all 0.
  - The next input pixel is tagged out_sof=1.
- Gapped input: valid_i toggling 1,0,1,0.
  - Counters advance only on valid cycles, so eol is on the 4th valid pixel.
  - No entries are created on idle cycles.
- With FRAMER_GRAY_EN defined: pixel at (3,2) with R=0x40, G=0x80, B=0xC0.
  - All three output channels equal 0x80.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the convolution output path.
//   pixel_t        - one colour channel
//   framer_entry_t - one buffered output pixel with its frame tags
//   BORDER         - border width for the default kernel size
package conv_pkg;

    localparam int PIXEL_DEPTH = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int BORDER      = KERNEL_SIZE - 1;

    typedef logic [PIXEL_DEPTH-1:0] pixel_t;

    typedef struct packed {
        logic   sof;
        logic   eol;
        pixel_t r;
        pixel_t g;
        pixel_t b;
    } framer_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head-of-queue output.
//   clk, rst_n   - clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  - write request; taken when not full, or when full and popping
//   pop          - read request; ignored when empty
//   rdata        - head entry; holds its last value while empty (0 after reset)
//   full, empty  - occupancy flags
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_nxt;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            // rdata tracks the next head: the following stored entry, or the
            // entry being written when it is about to become the only one.
            if (do_pop) begin
                if (count > (AW+1)'(1)) rdata <= mem[rd_nxt];
                else if (do_push)       rdata <= wdata;
            end else if (empty && do_push) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/conv_output_framer.sv
// conv_output_framer: frames the unframed conv_kernel pixel stream.
// Tracks x/y, zeroes border pixels whose window was incomplete, tags
// start-of-frame / end-of-line and buffers entries for a valid/ready sink.
// conv_kernel cannot be stalled, so a full FIFO drops pixels and sets the
// sticky overflow flag; position counters keep advancing regardless.
//   clk, rst_n                  - clock, synchronous active-low reset
//   valid_i, input_R/G/B        - incoming pixel
//   out_valid, out_ready        - output handshake
//   output_R/G/B, out_sof/eol   - framed pixel and tags
//   overflow                    - sticky drop indicator
//   frame_done                  - pulse the cycle after the last pixel is taken
// Optional: define FRAMER_GRAY_EN to store gray = (R + 2G + B) >> 2 on all
// three channels for non-border pixels.
// Entry channel width follows conv_pkg::PIXEL_DEPTH.
module conv_output_framer #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIXEL_DEPTH  = conv_pkg::PIXEL_DEPTH,
    parameter int KERNEL_SIZE  = conv_pkg::KERNEL_SIZE,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [PIXEL_DEPTH-1:0] input_R,
    input  logic [PIXEL_DEPTH-1:0] input_G,
    input  logic [PIXEL_DEPTH-1:0] input_B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_DEPTH-1:0] output_R,
    output logic [PIXEL_DEPTH-1:0] output_G,
    output logic [PIXEL_DEPTH-1:0] output_B,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   overflow,
    output logic                   frame_done
);

    import conv_pkg::*;

    localparam int XW       = $clog2(LINE_WIDTH);
    localparam int YW       = $clog2(FRAME_HEIGHT);
    localparam int BORDER_W = KERNEL_SIZE - 1;

    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic                   x_last, y_last, in_border;
    logic                   full, empty, pop;
    logic [PIXEL_DEPTH-1:0] pix_r, pix_g, pix_b;
    framer_entry_t          wr_entry, rd_entry;

    assign x_last    = (x == XW'(LINE_WIDTH - 1));
    assign y_last    = (y == YW'(FRAME_HEIGHT - 1));
    assign in_border = (x < XW'(BORDER_W)) || (y < YW'(BORDER_W));

`ifdef FRAMER_GRAY_EN
    logic [PIXEL_DEPTH+1:0] gray_sum;
    assign gray_sum = {2'b00, input_R} + {1'b0, input_G, 1'b0} + {2'b00, input_B};
    assign pix_r = in_border ? '0 : gray_sum[PIXEL_DEPTH+1:2];
    assign pix_g = pix_r;
    assign pix_b = pix_r;
`else
    assign pix_r = in_border ? '0 : input_R;
    assign pix_g = in_border ? '0 : input_G;
    assign pix_b = in_border ? '0 : input_B;
`endif

    // Tags use the position of the pixel being presented, before the advance.
    assign wr_entry = '{sof: (x == '0) && (y == '0), eol: x_last,
                        r: pix_r, g: pix_g, b: pix_b};

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .WIDTH($bits(framer_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (valid_i),
        .pop  (pop),
        .wdata(wr_entry),
        .rdata(rd_entry),
        .full (full),
        .empty(empty)
    );

    assign output_R = rd_entry.r;
    assign output_G = rd_entry.g;
    assign output_B = rd_entry.b;
    assign out_sof  = rd_entry.sof;
    assign out_eol  = rd_entry.eol;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= valid_i && x_last && y_last;
            if (valid_i) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            // A full FIFO still takes the pixel if an entry leaves this cycle.
            if (valid_i && full && !pop) overflow <= 1'b1;
        end
    end

endmodule
